// File: rtl/vid_pkg.sv
// Shared definitions for the raster timing path: default 640x480 timing,
// pixel and coordinate types, and the run-control state encoding.
package vid_pkg;

  localparam int COORD_W = 12;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } vid_state_e;

endpackage

// File: rtl/vid_hv_counter.sv
// Horizontal/vertical raster position counters. Held at the origin while not
// running, so a restart always begins at pixel (0,0).
module vid_hv_counter
  import vid_pkg::*;
#(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               run,
  output logic [COORD_W-1:0] h_cnt,
  output logic [COORD_W-1:0] v_cnt,
  output logic               frame_last
);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  assign frame_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (srst || !run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vid_timing_gen.sv
// Raster timing generator: drives hsync/vsync/de and a pixel stream pulled
// from a show-ahead FIFO, starting and stopping only on frame boundaries.
module vid_timing_gen
  import vid_pkg::*;
#(
  parameter int     H_ACTIVE   = VGA_H_ACTIVE,
  parameter int     H_FP       = VGA_H_FP,
  parameter int     H_SYNC     = VGA_H_SYNC,
  parameter int     H_BP       = VGA_H_BP,
  parameter int     V_ACTIVE   = VGA_V_ACTIVE,
  parameter int     V_FP       = VGA_V_FP,
  parameter int     V_SYNC     = VGA_V_SYNC,
  parameter int     V_BP       = VGA_V_BP,
  parameter bit     SYNC_POL   = 1'b0,
  parameter pixel_t FILL_COLOR = 24'h000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_fifo_empty,
  input  pixel_t             i_fifo_data,
  output logic               o_fifo_rd,
  output logic               o_hsyn,
  output logic               o_vsyn,
  output logic               o_de,
  output pixel_t             o_data,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_frame_start,
  output logic               o_underflow,
  input  logic               i_underflow_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_ACT_END  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] H_SYNC_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] H_SYNC_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_ACT_END  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] V_SYNC_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] V_SYNC_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  vid_state_e         state_reg, state_next;
  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               frame_last, running, active, hsync_on, vsync_on;

  vid_hv_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_hv_counter (
    .clk        (i_clk),
    .srst       (i_rst),
    .run        (running),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .frame_last (frame_last)
  );

  assign running  = (state_reg != ST_IDLE);
  assign active   = running && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hsync_on = running && (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign vsync_on = running && (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  // Blocked during reset so a mid-frame reset cannot steal a pixel from the FIFO.
  assign o_fifo_rd = active && !i_fifo_empty && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (i_en) state_next = ST_RUN;
      ST_RUN:       if (!i_en) state_next = ST_STOP_PEND;
      ST_STOP_PEND: begin
        if (i_en)            state_next = ST_RUN;
        else if (frame_last) state_next = ST_IDLE;
      end
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hsyn        <= ~SYNC_POL;
      o_vsyn        <= ~SYNC_POL;
      o_de          <= 1'b0;
      o_data        <= '0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
      o_underflow   <= 1'b0;
    end else begin
      o_hsyn        <= hsync_on ? SYNC_POL : ~SYNC_POL;
      o_vsyn        <= vsync_on ? SYNC_POL : ~SYNC_POL;
      o_de          <= active;
      o_data        <= !active ? '0 : (i_fifo_empty ? FILL_COLOR : i_fifo_data);
      o_x           <= active ? h_cnt : '0;
      o_y           <= active ? v_cnt : '0;
      o_frame_start <= active && (h_cnt == '0) && (v_cnt == '0);
      // Set has priority so an underflow coinciding with a clear is not lost.
      if (active && i_fifo_empty) o_underflow <= 1'b1;
      else if (i_underflow_clr)   o_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen with a tiny 14x7 raster: a behavioural raster model
// feeds a scoreboard each cycle, plus a scenario table and a reset sequence.
module tb_vid_timing_gen;

  localparam int HA = 8, HFP = 2, HS = 2, HB = 2;
  localparam int VA = 4, VFP = 1, VS = 1, VB = 1;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [23:0] FILL = 24'hC0FFEE;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b0;
  logic        i_fifo_empty = 1'b0;
  logic [23:0] i_fifo_data = '0;
  logic        i_underflow_clr = 1'b0;
  logic        o_fifo_rd, o_hsyn, o_vsyn, o_de, o_frame_start, o_underflow;
  logic [23:0] o_data;
  logic [11:0] o_x, o_y;

  vid_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .FILL_COLOR(FILL)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
    .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data),
    .o_fifo_rd(o_fifo_rd), .o_hsyn(o_hsyn), .o_vsyn(o_vsyn), .o_de(o_de),
    .o_data(o_data), .o_x(o_x), .o_y(o_y), .o_frame_start(o_frame_start),
    .o_underflow(o_underflow), .i_underflow_clr(i_underflow_clr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        de, hsyn, vsyn, fs, und;
    logic [23:0] data;
    logic [11:0] x, y;
  } exp_t;

  typedef struct {
    string name;
    int    cycles;
    int    en_off, en_on, emp_at, clr_at;
    int    exp_de, exp_pops, exp_fs;
    bit    exp_und, exp_idle;
  } scen_t;

  exp_t        sb_q[$];
  int          total = 0, bad = 0;
  // reference model: mode 0 idle, 1 running, 2 stopping at frame end
  int          m_mode = 0, m_pos = 0;
  bit          m_und = 0;
  logic [23:0] fifo_head = 24'h123456;
  int          cyc = 0, n_de = 0, n_pops = 0, n_fs = 0, fs_first = -1, fs_second = -1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  task automatic step(input bit en, input bit emp, input bit clr, input bit rst);
    exp_t e, g;
    bit   act, rd;
    int   h, v;
    i_en = en; i_fifo_empty = emp; i_underflow_clr = clr; i_rst = rst;
    i_fifo_data = fifo_head;
    #1;
    h = m_pos % HT;
    v = m_pos / HT;
    act = !rst && (m_mode != 0) && (h < HA) && (v < VA);
    rd = o_fifo_rd;
    chk("fifo_rd", {31'd0, o_fifo_rd}, {31'd0, act && !emp});
    if (rst) begin
      e = '{de: 0, hsyn: 1, vsyn: 1, fs: 0, und: 0, data: 24'd0, x: 12'd0, y: 12'd0};
    end else begin
      e.de   = act;
      e.hsyn = !((m_mode != 0) && h >= HA + HFP && h < HA + HFP + HS);
      e.vsyn = !((m_mode != 0) && v >= VA + VFP && v < VA + VFP + VS);
      e.fs   = act && (m_pos == 0);
      e.und  = (act && emp) ? 1'b1 : (clr ? 1'b0 : m_und);
      e.data = act ? (emp ? FILL : fifo_head) : 24'd0;
      e.x    = act ? 12'(h) : 12'd0;
      e.y    = act ? 12'(v) : 12'd0;
    end
    sb_q.push_back(e);
    @(posedge i_clk);
    if (rd) begin
      n_pops++;
      fifo_head = 24'($urandom);
    end
    if (rst) begin
      m_mode = 0; m_pos = 0; m_und = 0;
    end else begin
      m_und = e.und;
      if (m_mode == 0) begin
        m_pos = 0;
        if (en) m_mode = 1;
      end else begin
        if (en) m_mode = 1;
        else if (m_mode == 2 && m_pos == FT - 1) m_mode = 0;
        else m_mode = 2;
        m_pos = (m_pos + 1) % FT;
        if (m_mode == 0) m_pos = 0;
      end
    end
    @(negedge i_clk);
    g = sb_q.pop_front();
    chk("de", {31'd0, o_de}, {31'd0, g.de});
    chk("hsyn", {31'd0, o_hsyn}, {31'd0, g.hsyn});
    chk("vsyn", {31'd0, o_vsyn}, {31'd0, g.vsyn});
    chk("frame_start", {31'd0, o_frame_start}, {31'd0, g.fs});
    chk("underflow", {31'd0, o_underflow}, {31'd0, g.und});
    chk("data", {8'd0, o_data}, {8'd0, g.data});
    chk("x", {20'd0, o_x}, {20'd0, g.x});
    chk("y", {20'd0, o_y}, {20'd0, g.y});
    if (o_de) n_de++;
    if (o_frame_start) begin
      n_fs++;
      if (fs_first < 0) fs_first = cyc;
      else if (fs_second < 0) fs_second = cyc;
    end
    cyc++;
  endtask

  task automatic clear_stats();
    n_de = 0; n_pops = 0; n_fs = 0; fs_first = -1; fs_second = -1; cyc = 0;
  endtask

  scen_t tbl[5];

  initial begin
    int tail_mark;
    bit en_now;
    // Pixel (x,y) of the first frame is on scenario cycle 1 + y*14 + x.
    tbl[0] = '{"free_run",   1 + 2*FT, -1, -1, -1, -1, 64, 64, 2, 0, 0};
    tbl[1] = '{"underflow",  110,      50, -1, 18, 40, 32, 31, 1, 0, 1};
    tbl[2] = '{"mid_stop",   110,      34, -1, -1, -1, 32, 32, 1, 0, 1};
    tbl[3] = '{"reenable",   1 + 2*FT, 20, 25, -1, -1, 64, 64, 2, 0, 0};
    tbl[4] = '{"set_vs_clr", 60,       -1, -1, 18, 18, 32, 31, 1, 1, 0};

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_hsyn", {31'd0, o_hsyn}, 32'd1);
    chk("rst_vsyn", {31'd0, o_vsyn}, 32'd1);
    chk("rst_de", {31'd0, o_de}, 32'd0);
    chk("rst_data", {8'd0, o_data}, 32'd0);
    chk("rst_underflow", {31'd0, o_underflow}, 32'd0);
    chk("rst_fifo_rd", {31'd0, o_fifo_rd}, 32'd0);

    for (int s = 0; s < 5; s++) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      clear_stats();
      tail_mark = 0;
      for (int c = 0; c < tbl[s].cycles; c++) begin
        if (c == tbl[s].cycles - 10) tail_mark = n_de;
        en_now = !(tbl[s].en_off >= 0 && c >= tbl[s].en_off &&
                   (tbl[s].en_on < 0 || c < tbl[s].en_on));
        step(en_now, c == tbl[s].emp_at, c == tbl[s].clr_at, 0);
      end
      $display("scenario %s: de=%0d pops=%0d fs=%0d und=%0d",
               tbl[s].name, n_de, n_pops, n_fs, o_underflow);
      chk({tbl[s].name, "_de_count"}, n_de, tbl[s].exp_de);
      chk({tbl[s].name, "_pop_count"}, n_pops, tbl[s].exp_pops);
      chk({tbl[s].name, "_fs_count"}, n_fs, tbl[s].exp_fs);
      chk({tbl[s].name, "_und_end"}, {31'd0, o_underflow}, {31'd0, tbl[s].exp_und});
      chk({tbl[s].name, "_first_fs"}, fs_first, 1);
      if (tbl[s].exp_fs == 2)
        chk({tbl[s].name, "_fs_gap"}, fs_second - fs_first, FT);
      if (tbl[s].exp_idle) begin
        chk({tbl[s].name, "_tail_de"}, n_de - tail_mark, 0);
        chk({tbl[s].name, "_idle_hsyn"}, {31'd0, o_hsyn}, 32'd1);
        chk({tbl[s].name, "_idle_vsyn"}, {31'd0, o_vsyn}, 32'd1);
        chk({tbl[s].name, "_idle_rd"}, {31'd0, o_fifo_rd}, 32'd0);
      end
    end

    // Reset asserted while pixel x=4 of line 0 is being produced.
    step(0, 0, 0, 1);
    clear_stats();
    step(1, 0, 0, 0);
    for (int c = 1; c < 5; c++) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    $display("reset_mid_line: pops_before=%0d de=%0d", n_pops, o_de);
    chk("rml_pops", n_pops, 4);
    chk("rml_de", {31'd0, o_de}, 32'd0);
    chk("rml_data", {8'd0, o_data}, 32'd0);
    chk("rml_hsyn", {31'd0, o_hsyn}, 32'd1);
    chk("rml_vsyn", {31'd0, o_vsyn}, 32'd1);
    chk("rml_rd", {31'd0, o_fifo_rd}, 32'd0);
    step(1, 0, 0, 0);
    chk("rml_restart_idle_de", {31'd0, o_de}, 32'd0);
    step(1, 0, 0, 0);
    $display("reset_mid_line restart: fs=%0d x=%0d y=%0d", o_frame_start, o_x, o_y);
    chk("rml_restart_fs", {31'd0, o_frame_start}, 32'd1);
    chk("rml_restart_de", {31'd0, o_de}, 32'd1);
    chk("rml_restart_x", {20'd0, o_x}, 32'd0);
    chk("rml_restart_y", {20'd0, o_y}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
